phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 5, number of instruction phases (range 2..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of the cycle and instruction counters.
REQ-003 SHALL have derived parameter PHASE_W, equal to clog2(NUM_PHASES), width of the binary phase output.
REQ-004 SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port exec  in  1  run/stop button level; the block acts on its rising edge only.
REQ-007 SHALL have port step_mode  in  1  0 = continuous run, 1 = single-instruction step.
REQ-008 SHALL have port halt_req  in  1  halt request from the control unit.
REQ-009 SHALL have port mem_wait  in  1  memory stall; holds the phase while high.
REQ-010 SHALL have port phase  out  PHASE_W  current phase number.
REQ-011 SHALL have port phase_onehot  out  NUM_PHASES  one-hot copy of phase.
REQ-012 SHALL have ports running and halted  out  1 each  state flags.
REQ-013 SHALL have port instr_done  out  1  one-cycle pulse per completed instruction.
REQ-014 SHALL have ports cycle_count and instr_count  out  CNT_W each  performance counters.

Function
REQ-015 SHALL implement three states: IDLE, RUN and HALTED, and SHALL assert running only in RUN and halted only in HALTED.
REQ-016 SHALL detect an exec rising edge by comparing exec with a one-cycle-delayed registered copy; holding exec high SHALL produce exactly one edge.
REQ-017 SHALL move from IDLE to RUN with phase 0 on an exec edge.
REQ-018 SHALL advance phase by 1 on each RUN cycle with mem_wait=0, and SHALL wrap from NUM_PHASES-1 to 0.
REQ-019 SHALL hold phase and phase_onehot unchanged on a RUN cycle with mem_wait=1.
REQ-020 SHALL treat an advance out of phase NUM_PHASES-1 as an instruction boundary.
REQ-021 SHALL, at an instruction boundary, assert instr_done in the next cycle for exactly one cycle and increment instr_count in that same cycle.
REQ-022 SHALL increment cycle_count on every RUN cycle, stalled or not, and SHALL hold it in IDLE and HALTED.
REQ-023 SHALL wrap both counters from 2^CNT_W-1 to 0 without any flag.
REQ-024 SHALL, on an exec edge in RUN with step_mode=0, latch a stop request; at the next boundary it SHALL go to IDLE with phase 0 and clear the request.
REQ-025 SHALL, with step_mode=1, go to IDLE with phase 0 at the first boundary after entering RUN.
REQ-026 SHALL, when halt_req=1 at a boundary, go to HALTED with phase 0; halt_req SHALL be ignored at all other times.
REQ-027 SHALL give halt priority over a stop request or a step return when both fall at the same boundary.
REQ-028 SHALL latch an exec edge that arrives while mem_wait=1 and SHALL apply it at the next boundary.
REQ-029 SHALL ignore exec, step_mode and mem_wait in HALTED; only reset SHALL leave HALTED.
REQ-030 SHALL sample a step_mode change in RUN only at the next boundary.

Reset
REQ-031 SHALL, while reset=0 and regardless of clock, force IDLE state, phase=0, phase_onehot=1, running=0, halted=0, instr_done=0, cycle_count=0, instr_count=0, and clear the stop request and edge-detect register.
REQ-032 SHALL abandon any in-flight instruction when reset is asserted mid-operation, with no partial count update.

Structure
REQ-033 SHALL take the state enum, default NUM_PHASES and default CNT_W from shared package phase_seq_pkg.
REQ-034 SHALL place exec edge detection in one sub-module, exec_edge, with clock, reset, in and pulse ports.

Verification (NUM_PHASES=5 unless stated)
REQ-035 SHALL cover continuous run: one exec pulse, step_mode=0, no stalls -> phase sequence 0,1,2,3,4,0,..; after 10 RUN cycles cycle_count=10, instr_count=2, and instr_done has pulsed twice.
REQ-036 SHALL cover a stall: mem_wait=1 for 3 cycles in phase 2 -> phase stays 2 for 4 cycles, the instruction takes 8 cycles, cycle_count=8 and instr_count=1.
REQ-037 SHALL cover single step: step_mode=1 and one exec pulse -> exactly 5 RUN cycles, then IDLE, phase=0 and instr_count=1; a second pulse gives instr_count=2.
REQ-038 SHALL cover halt with a simultaneous stop: halt_req=1 in phase 4 and an exec edge in the same cycle -> HALTED with halted=1, running=0, instr_count incremented; later exec pulses change nothing.
REQ-039 SHALL cover counter wrap: CNT_W=4 and 16 RUN cycles -> cycle_count=0 and instr_count=3.
REQ-040 SHALL cover reset mid-run: reset=0 in phase 3 between clock edges -> all outputs at reset values immediately; after release, an exec pulse restarts from phase 0.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer.
// Contents: sequencer state enum and the default phase count / counter width.
package phase_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_PHASES = 5;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the sequencer and its controller.
// Controller -> sequencer: exec, step_mode, halt_req, mem_wait.
// Sequencer -> controller: phase, phase_onehot, running, halted, instr_done,
//                          cycle_count, instr_count, state (debug view of the FSM).
// Signalling: there is no valid/ready pairing here. The sequencer samples every
// input on each rising clock edge. It acts only on the rising edge of exec.
// mem_wait and step_mode are levels. halt_req matters only in the cycle that
// closes an instruction. instr_done is a one-cycle pulse.
interface phase_sequencer_if
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W
);
    localparam int PHASE_W = $clog2(NUM_PHASES);

    logic               exec;
    logic               step_mode;
    logic               halt_req;
    logic               mem_wait;
    logic [PHASE_W-1:0] phase;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic               running;
    logic               halted;
    logic               instr_done;
    logic [CNT_W-1:0]   cycle_count;
    logic [CNT_W-1:0]   instr_count;
    seq_state_t         state;

    modport master (
        output exec, step_mode, halt_req, mem_wait,
        input  phase, phase_onehot, running, halted, instr_done,
               cycle_count, instr_count, state
    );

    modport slave (
        input  exec, step_mode, halt_req, mem_wait,
        output phase, phase_onehot, running, halted, instr_done,
               cycle_count, instr_count, state
    );
endinterface

// File: rtl/exec_edge.sv
// Rising-edge detector for the exec button level.
// Ports: clock, reset (async active-low), in (level), pulse (high for the one
// cycle in which in is high and was low in the previous cycle).
module exec_edge (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic in_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) in_q <= 1'b0;
        else        in_q <= in;
    end

    assign pulse = in & ~in_q;
endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer with run/stop, single-step and halt control.
// Ports: clock, reset (async active-low), bus (phase_sequencer_if.slave) carrying
// the exec/step_mode/halt_req/mem_wait controls and the phase, flag and
// performance-counter outputs.
module phase_sequencer
    import phase_seq_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    phase_sequencer_if.slave bus
);
    localparam int PHASE_W = $clog2(NUM_PHASES);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    seq_state_t          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                stop_q, stop_d;
    logic                boundary;
    logic                done_q;
    logic [CNT_W-1:0]    cycle_q;
    logic [CNT_W-1:0]    instr_q;
    logic                exec_pulse;
    logic [NUM_PHASES-1:0] onehot;

    exec_edge u_exec_edge (
        .clock (clock),
        .reset (reset),
        .in    (bus.exec),
        .pulse (exec_pulse)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            stop_q  <= stop_d;
            done_q  <= boundary;
            if (state_q == RUN) cycle_q <= cycle_q + 1'b1;
            if (boundary)       instr_q <= instr_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        stop_d   = stop_q;
        boundary = 1'b0;
        case (state_q)
            IDLE: begin
                if (exec_pulse) begin
                    state_d = RUN;
                    phase_d = '0;
                    stop_d  = 1'b0;
                end
            end
            RUN: begin
                // An edge during a stall is latched the same way. It then takes
                // effect at the boundary that follows.
                if (exec_pulse && !bus.step_mode) stop_d = 1'b1;
                if (!bus.mem_wait) begin
                    if (phase_q == LAST_PHASE) begin
                        boundary = 1'b1;
                        phase_d  = '0;
                        // Halt wins over a pending stop or a step return.
                        if (bus.halt_req)                 state_d = HALTED;
                        else if (stop_d || bus.step_mode) state_d = IDLE;
                        stop_d = 1'b0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            HALTED: begin
                // Only reset leaves this state.
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                stop_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        onehot          = '0;
        onehot[phase_q] = 1'b1;
    end

    assign bus.phase        = phase_q;
    assign bus.phase_onehot = onehot;
    assign bus.running      = (state_q == RUN);
    assign bus.halted       = (state_q == HALTED);
    assign bus.instr_done   = done_q;
    assign bus.cycle_count  = cycle_q;
    assign bus.instr_count  = instr_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. Instance a uses the default NUM_PHASES=5
// and CNT_W=32. Instance b uses CNT_W=4 to exercise counter wrap.
module tb_phase_sequencer;
    import phase_seq_pkg::*;

    logic clock;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   done_pulses;
    logic [31:0] exp_q[$];

    phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(32)) bus_a ();
    phase_sequencer_if #(.NUM_PHASES(5), .CNT_W(4))  bus_b ();

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(32)) dut_a (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus_a.slave)
    );

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(4)) dut_b (
        .clock (clock),
        .reset (rst_n),
        .bus   (bus_b.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each tick leaves the bench 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_a.exec = 1'b0; bus_a.step_mode = 1'b0; bus_a.halt_req = 1'b0; bus_a.mem_wait = 1'b0;
        bus_b.exec = 1'b0; bus_b.step_mode = 1'b0; bus_b.halt_req = 1'b0; bus_b.mem_wait = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One-cycle exec pulse on instance a. It consumes one clock.
    task automatic pulse_exec_a();
        bus_a.exec = 1'b1;
        tick();
        bus_a.exec = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_phase"},  32'(bus_a.phase), 0);
        check({tag, "_onehot"}, 32'(bus_a.phase_onehot), 1);
        check({tag, "_run"},    32'(bus_a.running), 0);
        check({tag, "_halt"},   32'(bus_a.halted), 0);
        check({tag, "_done"},   32'(bus_a.instr_done), 0);
        check({tag, "_cyc"},    bus_a.cycle_count, 0);
        check({tag, "_ins"},    bus_a.instr_count, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check_reset_a("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Continuous run: phases 0..4 twice, then a stop request.
        pulse_exec_a();
        check("cont_enter_run", 32'(bus_a.running), 1);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i % 5));
        done_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            check("cont_phase", 32'(bus_a.phase), exp_q.pop_front());
            tick();
            if (bus_a.instr_done) done_pulses++;
        end
        check("cont_cyc10", bus_a.cycle_count, 10);
        check("cont_ins2", bus_a.instr_count, 2);
        check("cont_done2", 32'(done_pulses), 2);
        pulse_exec_a();                       // stop request during phase 0
        check("stop_still_run", 32'(bus_a.running), 1);
        for (int i = 0; i < 4; i++) tick();
        check("stop_idle", 32'(bus_a.running), 0);
        check("stop_phase0", 32'(bus_a.phase), 0);
        check("stop_ins3", bus_a.instr_count, 3);
        check("stop_cyc15", bus_a.cycle_count, 15);
        check("stop_done", 32'(bus_a.instr_done), 1);
        for (int i = 0; i < 3; i++) tick();
        check("idle_cyc_hold", bus_a.cycle_count, 15);
        check("idle_done_low", 32'(bus_a.instr_done), 0);

        // Stall in phase 2, with an exec edge arriving mid-stall.
        do_reset();
        pulse_exec_a();
        tick();
        tick();
        check("stall_phase2", 32'(bus_a.phase), 2);
        bus_a.mem_wait = 1'b1;
        bus_a.exec = 1'b1;
        tick();
        bus_a.exec = 1'b0;
        check("stall_hold1", 32'(bus_a.phase), 2);
        check("stall_onehot", 32'(bus_a.phase_onehot), 32'h4);
        tick();
        check("stall_hold2", 32'(bus_a.phase), 2);
        tick();
        check("stall_hold3", 32'(bus_a.phase), 2);
        bus_a.mem_wait = 1'b0;
        tick();
        check("stall_phase3", 32'(bus_a.phase), 3);
        tick();
        tick();
        check("stall_idle", 32'(bus_a.running), 0);
        check("stall_cyc8", bus_a.cycle_count, 8);
        check("stall_ins1", bus_a.instr_count, 1);

        // Single step, with exec held high through the whole instruction.
        do_reset();
        bus_a.step_mode = 1'b1;
        bus_a.exec = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("step_run_p4", 32'(bus_a.running), 1);
        check("step_p4", 32'(bus_a.phase), 4);
        tick();
        check("step_idle", 32'(bus_a.running), 0);
        check("step_ins1", bus_a.instr_count, 1);
        check("step_cyc5", bus_a.cycle_count, 5);
        for (int i = 0; i < 3; i++) tick();
        check("step_held_idle", 32'(bus_a.running), 0);
        check("step_held_cyc", bus_a.cycle_count, 5);
        bus_a.exec = 1'b0;
        tick();
        pulse_exec_a();
        for (int i = 0; i < 5; i++) tick();
        check("step2_idle", 32'(bus_a.running), 0);
        check("step2_phase", 32'(bus_a.phase), 0);
        check("step2_ins2", bus_a.instr_count, 2);

        // Halt: ignored mid-instruction, taken at the boundary even with an exec edge.
        do_reset();
        pulse_exec_a();
        bus_a.halt_req = 1'b1;
        tick();
        bus_a.halt_req = 1'b0;
        check("halt_ignored_run", 32'(bus_a.running), 1);
        check("halt_ignored_hlt", 32'(bus_a.halted), 0);
        tick();
        tick();
        tick();
        check("halt_at_p4", 32'(bus_a.phase), 4);
        bus_a.halt_req = 1'b1;
        bus_a.exec = 1'b1;
        tick();
        bus_a.halt_req = 1'b0;
        bus_a.exec = 1'b0;
        check("halt_halted", 32'(bus_a.halted), 1);
        check("halt_running", 32'(bus_a.running), 0);
        check("halt_phase", 32'(bus_a.phase), 0);
        check("halt_ins1", bus_a.instr_count, 1);
        check("halt_state", 32'(bus_a.state), 32'(HALTED));
        tick();
        pulse_exec_a();
        bus_a.mem_wait = 1'b1;
        tick();
        pulse_exec_a();
        bus_a.mem_wait = 1'b0;
        tick();
        check("halt_stays", 32'(bus_a.halted), 1);
        check("halt_cyc_hold", bus_a.cycle_count, 5);
        check("halt_ins_hold", bus_a.instr_count, 1);

        // Reset asserted between clock edges while in phase 3.
        do_reset();
        pulse_exec_a();
        tick();
        tick();
        tick();
        check("mid_p3", 32'(bus_a.phase), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        pulse_exec_a();
        check("restart_run", 32'(bus_a.running), 1);
        check("restart_p0", 32'(bus_a.phase), 0);
        tick();
        check("restart_p1", 32'(bus_a.phase), 1);

        // Counter wrap on the 4-bit instance.
        do_reset();
        bus_b.exec = 1'b1;
        tick();
        bus_b.exec = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("wrap_cyc15", bus_b.cycle_count, 15);
        tick();
        check("wrap_cyc0", bus_b.cycle_count, 0);
        check("wrap_ins3", bus_b.instr_count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
